i2c_wbs_host_arbiter: RTL and testbench
=======================================

// Module: i2c_wbs_host_arbiter
// PURPOSE
//  Shares the single 8-bit Wishbone host port of i2c_master_wbs_8 between two requesters (m0, m1).
//  Round-robin arbitration on cyc; the winner keeps the port until it drops cyc (locked multi-access
//  sequences, e.g. address/command/data/status-poll). Ack watchdog aborts a hung access with err.
//  Sits between the requesters and the DUT host interface inside the interfaced top level.
// PARAMETERS
//  ADDR_WIDTH   3    Wishbone address width (matches DUT register space)
//  DATA_WIDTH   8    Wishbone data width
//  TIMEOUT      255  max cycles stb_o may stay high without ack_i before abort (>=2)
// PORTS
//  clk          in   1           single clock, all logic rising-edge
//  rst          in   1           synchronous, active-high reset
//  mN_adr_i     in   ADDR_WIDTH  requester N address (N = 0,1; all mN_* ports duplicated per requester)
//  mN_dat_i     in   DATA_WIDTH  requester N write data
//  mN_dat_o     out  DATA_WIDTH  read data to requester N
//  mN_we_i      in   1           requester N write enable
//  mN_stb_i     in   1           requester N strobe
//  mN_ack_o     out  1           ack to requester N
//  mN_err_o     out  1           one-cycle error pulse: watchdog abort
//  mN_cyc_i     in   1           requester N cycle / bus request
//  wbs_adr_o    out  ADDR_WIDTH  to DUT wbs_adr_i
//  wbs_dat_o    out  DATA_WIDTH  to DUT wbs_dat_i
//  wbs_dat_i    in   DATA_WIDTH  from DUT wbs_dat_o
//  wbs_we_o     out  1           to DUT wbs_we_i
//  wbs_stb_o    out  1           to DUT wbs_stb_i
//  wbs_ack_i    in   1           from DUT wbs_ack_o
//  wbs_cyc_o    out  1           to DUT wbs_cyc_i
// BEHAVIOUR
//  Reset: state IDLE, rr pointer = 0 (m0 preferred), counter = 0; every output 0.
//  FSM: IDLE -> OWN (owner latched) -> IDLE on owner cyc low; OWN -> ABORT on timeout;
//       ABORT -> IDLE when owner cyc low. Registered grant: 1-cycle latency cyc request -> cyc_o.
//  IDLE: only m0 cyc -> owner 0; only m1 -> owner 1; both -> owner = rr; cyc_o/stb_o = 0.
//  OWN: wbs_cyc_o = 1; adr/dat/we/stb forwarded combinationally from owner (stb = owner stb_i).
//       Non-owner inputs ignored; non-owner ack/err/dat_o held 0.
//  Ack: wbs_ack_i routed combinationally to owner ack_o, wbs_dat_i to owner dat_o
//       (dat_o = 0 when ack_o low). Requester drops stb after ack per Wishbone classic.
//  Release: owner cyc low in OWN/ABORT -> IDLE next cycle, rr = other requester; guaranteed
//       >=1 cycle with wbs_cyc_o = 0 between tenures; a waiting requester wins the next IDLE.
//  Watchdog: counter++ each cycle wbs_stb_o=1 and wbs_ack_i=0; cleared on ack or stb low.
//       At count == TIMEOUT-1 with no ack: owner err_o = 1 for that cycle, next state ABORT.
//       Ack and timeout in the same cycle: ack wins, no err, counter cleared.
//  ABORT: wbs_cyc_o = wbs_stb_o = 0, acks ignored, err not repeated, wait for owner cyc low.
//  Owner drops cyc mid-access (stb high, no ack): cyc_o/stb_o go low next cycle; a late ack
//       is discarded.
//  rst mid-tenure: IDLE next edge, outputs 0; rr back to 0; in-flight access abandoned.
// STRUCTURE
//  Package i2c_wbs_arb_pkg: arb_state_t {IDLE, OWN, ABORT}, req_idx_t (1 bit), NUM_REQ = 2.
//  One sub-module: wbs_ack_watchdog (counter, TIMEOUT param, clear/enable in, expire out).
//  Arbiter FSM + muxing in this file; counter width $clog2(TIMEOUT+1).
// TESTING
//  1) m0 alone: cyc+stb write adr=3 dat=0x81; DUT acks cycle 3 -> m0_ack_o=1 same cycle, m1 quiet.
//  2) Both cyc rise same cycle after reset -> m0 granted; after m0 release m1 granted,
//     wbs_cyc_o low exactly 1 cycle between tenures; next simultaneous request -> m0 (rr).
//  3) Locked sequence: m1 holds cyc over 3 accesses (adr 2, 3, 0 poll) while m0 requests ->
//     m0 not granted until m1 cyc low; no m0 ack/dat leakage.
//  4) Read: m0 read adr=0, DUT returns 0x5A with ack -> m0_dat_o=0x5A on ack, m1_dat_o=0.
//  5) No ack, TIMEOUT=8: m0_err_o pulses once 8 cycles after stb rise, stb_o/cyc_o drop next
//     cycle, IDLE after m0 cyc low; variant ack on cycle 8 -> ack, no err.
//  6) rst asserted mid-access of m1 -> all outputs 0 next edge; afterwards m0 wins tie.

Source files
------------

// File: rtl/i2c_wbs_arb_pkg.sv
// Shared types for the two-requester Wishbone host-port arbiter.
package i2c_wbs_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/wbs_ack_watchdog.sv
// Counts cycles a strobe waits for ack; flags expiry on the last allowed cycle.
module wbs_ack_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_wbs_host_arbiter.sv
// Round-robin, cyc-locked arbiter sharing one Wishbone host port between m0 and m1,
// with an ack watchdog that aborts a hung access by pulsing err to the owner.
module i2c_wbs_host_arbiter
  import i2c_wbs_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  input  logic                  m0_we_i,
  input  logic                  m0_stb_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m0_cyc_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  input  logic                  m1_we_i,
  input  logic                  m1_stb_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  input  logic                  m1_cyc_i,
  output logic [ADDR_WIDTH-1:0] wbs_adr_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_we_o,
  output logic                  wbs_stb_o,
  input  logic                  wbs_ack_i,
  output logic                  wbs_cyc_o
);

  arb_state_t state_q, state_d;
  req_idx_t   owner_q, owner_d;
  req_idx_t   rr_q, rr_d;

  logic own;
  logic owner_cyc;
  logic owner_stb;
  logic expire;
  logic ack_route;
  logic err_pulse;

  assign own       = (state_q == OWN);
  assign owner_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign owner_stb = owner_q ? m1_stb_i : m0_stb_i;

  // Grant is registered, so the bus only follows the owner once state_q says OWN.
  assign wbs_cyc_o = own;
  assign wbs_stb_o = own && owner_stb;
  assign wbs_adr_o = own ? (owner_q ? m1_adr_i : m0_adr_i) : '0;
  assign wbs_dat_o = own ? (owner_q ? m1_dat_i : m0_dat_i) : '0;
  assign wbs_we_o  = own && (owner_q ? m1_we_i : m0_we_i);

  assign ack_route = own && wbs_ack_i;
  assign err_pulse = own && expire;

  assign m0_ack_o = ack_route && (owner_q == 1'b0);
  assign m1_ack_o = ack_route && (owner_q == 1'b1);
  assign m0_dat_o = m0_ack_o ? wbs_dat_i : '0;
  assign m1_dat_o = m1_ack_o ? wbs_dat_i : '0;
  assign m0_err_o = err_pulse && (owner_q == 1'b0);
  assign m1_err_o = err_pulse && (owner_q == 1'b1);

  wbs_ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!(wbs_stb_o && !wbs_ack_i)),
    .enable_i (wbs_stb_o && !wbs_ack_i),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          owner_d = rr_q;
          state_d = OWN;
        end else if (m0_cyc_i) begin
          owner_d = 1'b0;
          state_d = OWN;
        end else if (m1_cyc_i) begin
          owner_d = 1'b1;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          rr_d    = ~owner_q;
        end else if (expire) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          rr_d    = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_i2c_wbs_host_arbiter.sv
// Directed bench for the host-port arbiter; the bench itself plays the DUT slave side.
module tb_i2c_wbs_host_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] m0_adr, m1_adr;
  logic [7:0] m0_dat, m1_dat;
  logic [7:0] m0_dat_o, m1_dat_o;
  logic       m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
  logic       m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [2:0] wbs_adr_o;
  logic [7:0] wbs_dat_o, wbs_dat_i;
  logic       wbs_we_o, wbs_stb_o, wbs_ack_i, wbs_cyc_o;

  int n_checks = 0;
  int n_fails  = 0;

  logic [2:0] seq_adr [3];
  logic [7:0] seq_rd  [3];

  always #5 clk = ~clk;

  i2c_wbs_host_arbiter #(
    .ADDR_WIDTH (3),
    .DATA_WIDTH (8),
    .TIMEOUT    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_adr_i  (m0_adr),
    .m0_dat_i  (m0_dat),
    .m0_dat_o  (m0_dat_o),
    .m0_we_i   (m0_we),
    .m0_stb_i  (m0_stb),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m0_cyc_i  (m0_cyc),
    .m1_adr_i  (m1_adr),
    .m1_dat_i  (m1_dat),
    .m1_dat_o  (m1_dat_o),
    .m1_we_i   (m1_we),
    .m1_stb_i  (m1_stb),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .m1_cyc_i  (m1_cyc),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_dat_i (wbs_dat_i),
    .wbs_we_o  (wbs_we_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_ack_i (wbs_ack_i),
    .wbs_cyc_o (wbs_cyc_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clr_inputs();
    m0_adr = '0; m0_dat = '0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    seq_adr[0] = 3'd2; seq_adr[1] = 3'd3; seq_adr[2] = 3'd0;
    seq_rd[0]  = 8'h11; seq_rd[1] = 8'h33; seq_rd[2] = 8'h22;

    // Reset state
    clr_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cyc", 8'(wbs_cyc_o), 8'h0);
    chk("rst_stb", 8'(wbs_stb_o), 8'h0);
    chk("rst_adr", 8'(wbs_adr_o), 8'h0);
    chk("rst_acks", 8'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 8'h0);
    rst = 1'b0;

    // 1) m0 alone, write adr=3 dat=0x81, ack on cycle 3
    m0_adr = 3'd3; m0_dat = 8'h81; m0_we = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    chk("t1_idle_cyc", 8'(wbs_cyc_o), 8'h0);
    tick();
    chk("t1_cyc", 8'(wbs_cyc_o), 8'h1);
    chk("t1_stb", 8'(wbs_stb_o), 8'h1);
    chk("t1_adr", 8'(wbs_adr_o), 8'h3);
    chk("t1_dat", wbs_dat_o, 8'h81);
    chk("t1_we", 8'(wbs_we_o), 8'h1);
    tick();
    chk("t1_noack", 8'(m0_ack_o), 8'h0);
    tick();
    wbs_ack_i = 1'b1;
    #1;
    chk("t1_m0_ack", 8'(m0_ack_o), 8'h1);
    chk("t1_m1_quiet", 8'({m1_ack_o, m1_err_o}), 8'h0);
    chk("t1_m1_dat", m1_dat_o, 8'h0);
    tick();
    wbs_ack_i = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
    #1;
    chk("t1_release_cyc", 8'(wbs_cyc_o), 8'h1);
    tick();
    chk("t1_idle_after", 8'(wbs_cyc_o), 8'h0);

    // 2) simultaneous request after reset, then round-robin
    do_reset();
    m0_adr = 3'd1; m1_adr = 3'd6;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    chk("t2_m0_first_adr", 8'(wbs_adr_o), 8'h1);
    wbs_ack_i = 1'b1;
    #1;
    chk("t2_m0_ack", 8'(m0_ack_o), 8'h1);
    chk("t2_m1_noack", 8'(m1_ack_o), 8'h0);
    tick();
    wbs_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("t2_m0_tail_cyc", 8'(wbs_cyc_o), 8'h1);
    tick();
    chk("t2_gap_cyc", 8'(wbs_cyc_o), 8'h0);
    tick();
    chk("t2_m1_cyc", 8'(wbs_cyc_o), 8'h1);
    chk("t2_m1_adr", 8'(wbs_adr_o), 8'h6);
    wbs_ack_i = 1'b1;
    #1;
    chk("t2_m1_ack", 8'(m1_ack_o), 8'h1);
    chk("t2_m0_noack", 8'(m0_ack_o), 8'h0);
    tick();
    wbs_ack_i = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    chk("t2_idle_cyc", 8'(wbs_cyc_o), 8'h0);
    tick();
    chk("t2_rr_m0_adr", 8'(wbs_adr_o), 8'h1);

    // 3) m1 locked over three accesses while m0 waits
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
    tick();
    tick();
    m0_adr = 3'd5; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    chk("t3_m1_owns_cyc", 8'(wbs_cyc_o), 8'h1);
    chk("t3_m0_stb_ignored", 8'(wbs_stb_o), 8'h0);
    for (int i = 0; i < 3; i++) begin
      m1_adr = seq_adr[i]; m1_stb = 1'b1; m1_we = (i < 2); m1_dat = 8'h40 + 8'(i);
      #1;
      chk("t3_adr", 8'(wbs_adr_o), 8'(seq_adr[i]));
      tick();
      wbs_ack_i = 1'b1; wbs_dat_i = seq_rd[i];
      #1;
      chk("t3_m1_ack", 8'(m1_ack_o), 8'h1);
      chk("t3_m1_dat", m1_dat_o, seq_rd[i]);
      chk("t3_m0_leak", 8'(m0_ack_o), 8'h0);
      chk("t3_m0_dat_leak", m0_dat_o, 8'h0);
      tick();
      wbs_ack_i = 1'b0; wbs_dat_i = '0; m1_stb = 1'b0;
      tick();
    end
    m1_cyc = 1'b0;
    #1;
    chk("t3_tail_cyc", 8'(wbs_cyc_o), 8'h1);
    tick();
    chk("t3_gap_cyc", 8'(wbs_cyc_o), 8'h0);
    tick();
    chk("t3_m0_granted_adr", 8'(wbs_adr_o), 8'h5);
    chk("t3_m0_granted_stb", 8'(wbs_stb_o), 8'h1);

    // 4) m0 read adr=0 returning 0x5A
    m0_adr = 3'd0; m0_we = 1'b0;
    #1;
    chk("t4_dat_before_ack", m0_dat_o, 8'h0);
    wbs_dat_i = 8'h5A; wbs_ack_i = 1'b1;
    #1;
    chk("t4_m0_dat", m0_dat_o, 8'h5A);
    chk("t4_m0_ack", 8'(m0_ack_o), 8'h1);
    chk("t4_m1_dat", m1_dat_o, 8'h0);
    chk("t4_we", 8'(wbs_we_o), 8'h0);
    tick();
    wbs_ack_i = 1'b0; wbs_dat_i = '0; m0_stb = 1'b0; m0_cyc = 1'b0;
    tick();

    // 5) watchdog: no ack, TIMEOUT=8
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    for (int c = 1; c < 8; c++) begin
      chk("t5_no_err_early", 8'(m0_err_o), 8'h0);
      tick();
    end
    chk("t5_m0_err", 8'(m0_err_o), 8'h1);
    chk("t5_m1_err", 8'(m1_err_o), 8'h0);
    tick();
    wbs_ack_i = 1'b1;
    #1;
    chk("t5_abort_stb", 8'(wbs_stb_o), 8'h0);
    chk("t5_abort_cyc", 8'(wbs_cyc_o), 8'h0);
    chk("t5_abort_ack_ignored", 8'(m0_ack_o), 8'h0);
    tick();
    wbs_ack_i = 1'b0;
    #1;
    chk("t5_err_not_repeated", 8'(m0_err_o), 8'h0);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("t5_idle_cyc", 8'(wbs_cyc_o), 8'h0);

    // 5b) ack arrives on the timeout cycle: ack wins
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    for (int c = 1; c < 8; c++) begin
      tick();
    end
    wbs_ack_i = 1'b1;
    #1;
    chk("t5b_ack", 8'(m0_ack_o), 8'h1);
    chk("t5b_no_err", 8'(m0_err_o), 8'h0);
    tick();
    wbs_ack_i = 1'b0; m0_stb = 1'b0;
    #1;
    chk("t5b_still_own", 8'(wbs_cyc_o), 8'h1);
    chk("t5b_err_after", 8'(m0_err_o), 8'h0);
    m0_cyc = 1'b0;
    tick();
    tick();

    // 6) reset in the middle of an m1 access
    m1_adr = 3'd4; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    chk("t6_m1_cyc", 8'(wbs_cyc_o), 8'h1);
    chk("t6_m1_adr", 8'(wbs_adr_o), 8'h4);
    rst = 1'b1; wbs_ack_i = 1'b1;
    tick();
    chk("t6_rst_cyc", 8'(wbs_cyc_o), 8'h0);
    chk("t6_rst_stb", 8'(wbs_stb_o), 8'h0);
    chk("t6_rst_adr", 8'(wbs_adr_o), 8'h0);
    chk("t6_rst_m1_ack", 8'(m1_ack_o), 8'h0);
    chk("t6_rst_m1_dat", m1_dat_o, 8'h0);
    rst = 1'b0; wbs_ack_i = 1'b0;
    m0_adr = 3'd7; m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    chk("t6_m0_wins_tie", 8'(wbs_adr_o), 8'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
